// File: rtl/mul_hilo_acc.sv
// HI:LO multiply-accumulate commit stage: MULT/MADD/MSUB/CLR into a 64-bit HI:LO pair, plus MFHI/MFLO reads and MTHI/MTLO writes.
// Latency: op accept -> hi/lo visible after 2 edges (S1 capture, S2 commit); read accept -> rd_valid after 1 edge.
// Backpressure: in_ready drops while a read is pending so the pipe drains; the pipe itself never stalls.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid/in_ready, op,    product/op handshake (op: 00 MULT, 01 MADD, 10 MSUB, 11 CLR)
//   prod
//   rd_req/rd_ready, rd_sel,  HI/LO read handshake; rd_data registered, rd_valid one-cycle pulse
//   rd_data, rd_valid
//   wr_en, wr_sel, wr_data    direct half write (0=LO, 1=HI)
//   hi, lo, ovf, busy         architectural state, sticky overflow, op in flight
module mul_hilo_acc #(
  parameter int PW = 32,
  parameter int AW = 64   // must equal 2*PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    op,
  input  logic [PW-1:0] prod,
  input  logic          rd_req,
  input  logic          rd_sel,
  output logic          rd_ready,
  output logic [PW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [PW-1:0] wr_data,
  output logic [PW-1:0] hi,
  output logic [PW-1:0] lo,
  output logic          ovf,
  output logic          busy
);

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_MADD = 2'b01,
    OP_MSUB = 2'b10,
    OP_CLR  = 2'b11
  } op_t;

  // S1 capture registers
  logic          s1_v;
  op_t           s1_op;
  logic [AW-1:0] s1_p;

  // Architectural state
  logic [PW-1:0] hi_q;
  logic [PW-1:0] lo_q;
  logic          ovf_q;

  // S2 commit datapath
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [AW-1:0] diff;
  logic [AW-1:0] s2_res;
  logic          s2_ovf;
  logic [PW-1:0] nxt_hi;
  logic [PW-1:0] nxt_lo;
  logic          accept;

  // A pending read blocks new ops; the read itself waits until S1 is empty
  // so it observes every op issued before it.
  assign in_ready = !rd_req;
  assign accept   = in_valid && in_ready;
  assign rd_ready = rd_req && !s1_v;

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign ovf  = ovf_q;
  assign busy = s1_v;

  always_comb begin
    acc    = {hi_q, lo_q};
    sum    = acc + s1_p;
    diff   = acc - s1_p;
    s2_res = acc;
    s2_ovf = ovf_q;
    if (s1_v) begin
      case (s1_op)
        OP_MULT: s2_res = s1_p;
        OP_MADD: begin
          s2_res = sum;
          // same operand signs, result sign flipped
          if ((acc[AW-1] == s1_p[AW-1]) && (sum[AW-1] != acc[AW-1]))
            s2_ovf = 1'b1;
        end
        OP_MSUB: begin
          s2_res = diff;
          // subtracting is adding -s1_p, whose sign is the opposite of s1_p's
          if ((acc[AW-1] != s1_p[AW-1]) && (diff[AW-1] != acc[AW-1]))
            s2_ovf = 1'b1;
        end
        OP_CLR: begin
          s2_res = '0;
          s2_ovf = 1'b0;
        end
        default: s2_res = acc;
      endcase
    end

    // Direct write lands on top of the S2 result; the other half keeps S2.
    nxt_hi = s2_res[AW-1:PW];
    nxt_lo = s2_res[PW-1:0];
    if (wr_en) begin
      if (wr_sel) nxt_hi = wr_data;
      else        nxt_lo = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s1_op <= OP_MULT;
      s1_p  <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_op <= op_t'(op);
        s1_p  <= {{(AW-PW){prod[PW-1]}}, prod};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      hi_q  <= nxt_hi;
      lo_q  <= nxt_lo;
      ovf_q <= s2_ovf;
    end
  end

  // Reads return the value committed at the accepting edge, including any
  // same-cycle direct write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_ready;
      if (rd_ready)
        rd_data <= rd_sel ? nxt_hi : nxt_lo;
    end
  end

endmodule
